// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one synchronous FIFO write port
// between C_NUM_REQ producers. Each written word carries its source index in
// the MSBs so the downstream reducer can demultiplex.
module fifo_wr_arbiter #(
    parameter int C_NUM_REQ     = 4,
    parameter int C_LOG_NUM_REQ = 2,
    parameter int C_WIDTH       = 8,
    parameter int C_MAX_BURST   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [C_NUM_REQ-1:0]             req,
    input  logic [C_NUM_REQ-1:0]             req_last,
    input  logic [C_NUM_REQ*C_WIDTH-1:0]     req_data,
    output logic [C_NUM_REQ-1:0]             req_ack,
    input  logic                             fifo_full,
    output logic                             fifo_wr_en,
    output logic [C_LOG_NUM_REQ+C_WIDTH-1:0] fifo_din,
    output logic [C_LOG_NUM_REQ-1:0]         grant_id,
    output logic                             busy,
    output logic                             burst_err
);

    localparam int CNT_W = $clog2(C_MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_BEATS = CNT_W'(C_MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                   state;
    logic [C_LOG_NUM_REQ-1:0] rr_ptr;
    logic [CNT_W-1:0]         beat_cnt;
    logic [CNT_W-1:0]         beat_cnt_nxt;

    logic                     sel_found;
    logic [C_LOG_NUM_REQ-1:0] sel_id;
    logic [C_LOG_NUM_REQ-1:0] scan_idx;

    logic                     req_g;
    logic                     last_g;
    logic [C_WIDTH-1:0]       data_g;
    logic                     accept;

    // Round-robin scan starting at rr_ptr; wrap comes free from the
    // power-of-two index width.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = rr_ptr;
        scan_idx  = '0;
        for (int unsigned k = 0; k < C_NUM_REQ; k++) begin
            scan_idx = rr_ptr + C_LOG_NUM_REQ'(k);
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_id    = scan_idx;
            end
        end
    end

    // Select the granted requester's valid, last flag and data.
    always_comb begin
        req_g  = 1'b0;
        last_g = 1'b0;
        data_g = '0;
        for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
            if (grant_id == C_LOG_NUM_REQ'(i)) begin
                req_g  = req[i];
                last_g = req_last[i];
                data_g = req_data[i*C_WIDTH +: C_WIDTH];
            end
        end
    end

    // Write-side outputs: only the granted requester can be acked, never while full.
    always_comb begin
        accept       = (state == BURST) && req_g && !fifo_full;
        beat_cnt_nxt = beat_cnt + CNT_W'(1);
        fifo_wr_en   = accept;
        fifo_din     = {grant_id, data_g};
        req_ack      = '0;
        if (accept) begin
            req_ack[grant_id] = 1'b1;
        end
    end

    // Arbitration FSM with burst lock, forced release at C_MAX_BURST beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            burst_err <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            burst_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id <= sel_id;
                        state    <= BURST;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt_nxt;
                        if (last_g || (beat_cnt_nxt == MAX_BEATS)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            rr_ptr    <= grant_id + C_LOG_NUM_REQ'(1);
                            burst_err <= !last_g;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester models present queued
// beats, expected FIFO words are queued as stimulus is loaded and compared
// as writes appear.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int LW = 2;
    localparam int DW = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req;
    logic [NR-1:0]      req_last;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ack;
    logic               fifo_full;
    logic               fifo_wr_en;
    logic [LW+DW-1:0]   fifo_din;
    logic [LW-1:0]      grant_id;
    logic               busy;
    logic               burst_err;

    fifo_wr_arbiter #(
        .C_NUM_REQ    (NR),
        .C_LOG_NUM_REQ(LW),
        .C_WIDTH      (DW),
        .C_MAX_BURST  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .grant_id  (grant_id),
        .busy      (busy),
        .burst_err (burst_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // per-requester beat lists {last, data}
    logic [8:0]  beats [NR][32];
    int unsigned head  [NR];
    int unsigned tail  [NR];
    logic [NR-1:0] hold;

    logic [LW+DW-1:0] exp_q[$];
    int wr_count;
    int err_cnt;
    int cyc;
    int wr_cyc [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            if (head[i] < tail[i] && !hold[i]) begin
                req[i]                = 1'b1;
                req_last[i]           = beats[i][head[i]][8];
                req_data[i*DW +: DW]  = beats[i][head[i]][7:0];
            end else begin
                req[i]                = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic add_beat(input int r, input logic [7:0] d, input logic l, input bit expect_wr);
        beats[r][tail[r]] = {l, d};
        tail[r]++;
        if (expect_wr) exp_q.push_back({LW'(r), d});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_full = 1'b0;
        hold = '0;
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        drive_reqs();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wr_count = 0;
        err_cnt = 0;
    endtask

    task automatic wait_writes(input int target);
        int budget;
        budget = 200;
        while (wr_count < target && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (wr_count < target) check("timeout_writes", wr_count, target);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // cycle counter for write spacing
    always @(posedge clk) cyc <= cyc + 1;

    // requester models: retire a beat once acked, then present the next one
    initial begin
        logic [NR-1:0] ack_s;
        logic          rst_s;
        forever begin
            @(negedge clk);
            ack_s = req_ack;
            rst_s = rst;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (ack_s[i] && !rst_s && head[i] < tail[i]) head[i]++;
            end
            drive_reqs();
        end
    end

    // scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_wr_en) begin
                check("wr_while_full", fifo_full, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", fifo_din, '0);
                end else begin
                    check("fifo_din", fifo_din, exp_q.pop_front());
                end
                check("ack_onehot", req_ack, 32'(1) << fifo_din[LW+DW-1:DW]);
                if (wr_count < 64) wr_cyc[wr_count] = cyc;
                wr_count++;
            end else begin
                check("ack_no_write", req_ack, '0);
            end
            if (burst_err) err_cnt++;
        end
    end

    initial begin
        cyc = 0;
        req = '0;
        req_last = '0;
        req_data = '0;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_err", burst_err, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        tick(1);

        // single 3-beat burst from requester 0
        add_beat(0, 8'h11, 1'b0, 1'b1);
        add_beat(0, 8'h22, 1'b0, 1'b1);
        add_beat(0, 8'h33, 1'b1, 1'b1);
        drive_reqs();
        @(negedge clk);
        check("t1_no_wr_select", fifo_wr_en, 0);
        tick(1);
        check("t1_grant", grant_id, 0);
        check("t1_busy", busy, 1);
        tick(1);
        check("t1_wr1", wr_count, 1);
        tick(1);
        check("t1_wr2", wr_count, 2);
        tick(1);
        check("t1_wr3", wr_count, 3);
        check("t1_busy_end", busy, 0);

        // round robin among four single-beat requesters
        do_reset();
        add_beat(0, 8'hA0, 1'b1, 1'b1);
        add_beat(1, 8'hA1, 1'b1, 1'b1);
        add_beat(2, 8'hA2, 1'b1, 1'b1);
        add_beat(3, 8'hA3, 1'b1, 1'b1);
        add_beat(0, 8'hB0, 1'b1, 1'b1);
        drive_reqs();
        wait_writes(5);
        for (int k = 0; k < 4; k++) check("t2_gap", wr_cyc[k+1] - wr_cyc[k], 2);
        check("t2_grant_last", grant_id, 0);

        // requester 2 stalled by fifo_full mid-burst
        do_reset();
        add_beat(2, 8'h51, 1'b0, 1'b1);
        add_beat(2, 8'h52, 1'b0, 1'b1);
        add_beat(2, 8'h53, 1'b0, 1'b1);
        add_beat(2, 8'h54, 1'b1, 1'b1);
        drive_reqs();
        wait_writes(2);
        fifo_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_stall_wr", fifo_wr_en, 0);
            check("t3_stall_grant", grant_id, 2);
            check("t3_stall_busy", busy, 1);
            tick(1);
        end
        check("t3_count_stall", wr_count, 2);
        fifo_full = 1'b0;
        @(negedge clk);
        check("t3_full_release_wr", fifo_wr_en, 1);
        wait_writes(4);
        tick(3);
        check("t3_count_final", wr_count, 4);

        // forced release after C_MAX_BURST beats without last
        do_reset();
        for (int k = 0; k < 10; k++) add_beat(1, 8'(8'h60 + k), 1'b0, 1'b1);
        drive_reqs();
        wait_writes(8);
        check("t4_busy_release", busy, 0);
        check("t4_err_pulse", burst_err, 1);
        tick(1);
        check("t4_regrant", grant_id, 1);
        check("t4_rebusy", busy, 1);
        check("t4_err_clear", burst_err, 0);
        wait_writes(10);
        tick(2);
        check("t4_err_count", err_cnt, 1);
        check("t4_count", wr_count, 10);

        // reset mid-burst discards the rest
        do_reset();
        add_beat(3, 8'h71, 1'b0, 1'b1);
        add_beat(3, 8'h72, 1'b0, 1'b1);
        add_beat(3, 8'h73, 1'b0, 1'b0);
        add_beat(3, 8'h74, 1'b0, 1'b0);
        add_beat(3, 8'h75, 1'b1, 1'b0);
        drive_reqs();
        wait_writes(2);
        rst = 1'b1;
        head[3] = 0;
        tail[3] = 0;
        drive_reqs();
        tick(1);
        check("t5_busy", busy, 0);
        check("t5_grant", grant_id, 0);
        check("t5_wr_en", fifo_wr_en, 0);
        rst = 1'b0;
        tick(4);
        check("t5_no_more_writes", wr_count, 2);

        // granted requester drops req; no preemption by requester 1
        do_reset();
        add_beat(0, 8'h81, 1'b0, 1'b1);
        add_beat(0, 8'h82, 1'b0, 1'b1);
        add_beat(0, 8'h83, 1'b1, 1'b1);
        add_beat(1, 8'h91, 1'b1, 1'b1);
        drive_reqs();
        wait_writes(1);
        hold[0] = 1'b1;
        drive_reqs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_hold_wr", fifo_wr_en, 0);
            check("t6_hold_grant", grant_id, 0);
            tick(1);
        end
        hold[0] = 1'b0;
        drive_reqs();
        wait_writes(3);
        check("t6_release", busy, 0);
        tick(1);
        check("t6_grant1", grant_id, 1);
        wait_writes(4);

        tick(2);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares one write port of the team's synchronous FIFO between C_NUM_REQ producers, such as map workers.
- Grants are burst-locked: a granted requester owns the FIFO until it sends a beat flagged last.
- Each FIFO word is tagged with the source index so the downstream reducer can demultiplex.
- Sits directly in front of the FIFO instance and drives its wr_en/buf_in; it consumes the FIFO's buf_full.

Parameters:
- C_NUM_REQ, 4, number of requesters (power of two, >= 2).
- C_LOG_NUM_REQ, 2, log2(C_NUM_REQ); width of the source tag.
- C_WIDTH, 8, data width per requester.
- C_MAX_BURST, 8, maximum beats per grant before a forced release (>= 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  C_NUM_REQ  per-requester beat-valid.
- req_last  in  C_NUM_REQ  per-requester last-beat-of-burst flag, qualified by req.
- req_data  in  C_NUM_REQ*C_WIDTH  flattened data; requester i occupies bits [i*C_WIDTH +: C_WIDTH].
- req_ack  out  C_NUM_REQ  beat accepted this cycle; combinational, one-hot or zero.
- fifo_full  in  1  FIFO full indication.
- fifo_wr_en  out  1  FIFO write enable; combinational.
- fifo_din  out  C_LOG_NUM_REQ+C_WIDTH  {source_id, data}; source_id is in the MSBs.
- grant_id  out  C_LOG_NUM_REQ  currently or last granted requester; registered.
- busy  out  1  high while in BURST; registered.
- burst_err  out  1  one-cycle pulse on forced release; registered.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, grant_id=0, busy=0, burst_err=0, beat_cnt=0. While the arbiter is in IDLE (including out of reset), req_ack=0 and fifo_wr_en=0. rst takes priority over all other events, and a reset mid-burst discards the burst with no further writes.
- States: IDLE, BURST.
- IDLE: if any req bit is set, select the first index i with req[i]=1, scanning rr_ptr, rr_ptr+1, … modulo C_NUM_REQ. Next cycle: grant_id=i, state=BURST, busy=1, beat_cnt=0. Arbitration latency is 1 cycle; no beat is accepted in the selecting cycle. req_last is ignored in IDLE.
- BURST, with g=grant_id:
  - accept = req[g] & ~fifo_full.
  - req_ack[g] = accept; all other req_ack bits are 0.
  - fifo_wr_en = accept.
  - fifo_din = {g, req_data[g]}; it is don't-care when fifo_wr_en=0.
- Stalls: if req[g]=0 or fifo_full=1, there is no write and no ack, and the grant is held indefinitely. Other requesters cannot preempt.
- On an accepted beat:
  - beat_cnt increments.
  - If req_last[g]=1, or beat_cnt+1 == C_MAX_BURST, the burst ends: next state=IDLE, busy=0, rr_ptr=(g+1) mod C_NUM_REQ.
  - A release caused by C_MAX_BURST with req_last[g]=0 also pulses burst_err=1 for one cycle.
- Back-to-back: after release there is at least one IDLE cycle between bursts, so maximum throughput is C_MAX_BURST beats per C_MAX_BURST+1 cycles.
- Fairness: a requester that just released has the lowest priority next arbitration. A sole active requester may be regranted immediately.
- Requester contract: hold req, req_data and req_last stable until acked. A req drop without ack is legal and only stalls the burst.
- Full boundary:
  - The arbiter never asserts fifo_wr_en while fifo_full=1, so overflow is impossible.
  - A beat presented in the cycle fifo_full deasserts is accepted that cycle.
- grant_id holds its last value in IDLE.
- fifo_wr_en, req_ack and fifo_din are purely combinational from state, grant_id, req, req_last, req_data and fifo_full. There is no combinational path from req to fifo_wr_en in IDLE.

Test Plan:
- Reset, then req=0001 with a 3-beat burst (data 0x11, 0x22, 0x33; last on the third) and fifo_full=0. Required response:
  - grant_id=0 and busy=1 one cycle after req.
  - fifo_din = 0x011, 0x022, 0x033 on 3 consecutive cycles, with req_ack[0] on each.
  - busy=0 after the third beat.
- req=1111 held, each requester sending single-beat bursts with last=1 → grant order 0,1,2,3,0, each write separated by one IDLE cycle; fifo_din tags 0,1,2,3,0.
- Requester 2 in a burst with fifo_full=1 for 4 cycles mid-burst → no fifo_wr_en or req_ack in those cycles; grant_id stays 2; the burst resumes when fifo_full falls, with no beat lost or duplicated.
- Requester 1 streams 10 beats with no last, C_MAX_BURST=8 → exactly 8 writes, burst_err pulses once, state returns to IDLE, requester 1 is regranted and the remaining 2 beats are written.
- rst asserted after beat 2 of a 5-beat burst from requester 3 → next cycle busy=0, grant_id=0, fifo_wr_en=0, and there are no further writes until a new arbitration.
- Granted requester 0 drops req for 3 cycles while requester 1 requests → no grant change and no writes; requester 1 is granted only after requester 0 sends last.
